// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: one log-shifter level per stage, SAW stages.
// Latency SAW cycles; the whole pipe holds while a result waits on out_ready.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SAW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [SAW-1:0]   sa,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sh,
  output logic             zero,
  output logic             bad_op
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  if (WIDTH < 8 || SAW != $clog2(WIDTH) || (1 << SAW) != WIDTH) begin : g_param_check
    $error("shift_pipe: WIDTH must be a power of 2 >= 8 and SAW must equal log2(WIDTH)");
  end

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic [SAW-1:0]   sa;
    logic [WIDTH-1:0] dat;
  } stage_t;

  // Fixed-distance shift for one level; reserved ops pass data through untouched.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [2:0]       o,
                                                input int               amt);
    logic [WIDTH-1:0] r;
    r = x;
    case (o)
      OP_SLL:  r = x << amt;
      OP_SRL:  r = x >> amt;
      OP_SRA:  r = WIDTH'($signed(x) >>> amt);
      OP_ROL:  r = (x << amt) | (x >> (WIDTH - amt));
      OP_ROR:  r = (x >> amt) | (x << (WIDTH - amt));
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic stage_t apply_level(input stage_t s, input int k);
    stage_t r;
    r = s;
    if (s.sa[k]) r.dat = shift_by(s.dat, s.op, 1 << k);
    return r;
  endfunction

  logic   en;
  stage_t in_stg;
  stage_t lvl_src [SAW];
  stage_t stg_d   [SAW];
  stage_t stg_q   [SAW];
  logic   zero_d;
  logic   zero_q;

  assign en       = ~stg_q[SAW-1].vld | out_ready;
  assign in_ready = en & ~rst;

  always_comb begin
    in_stg     = '0;
    in_stg.vld = in_valid & ~rst;
    in_stg.op  = op;
    in_stg.sa  = sa;
    in_stg.dat = d;
  end

  // Stage i applies level SAW-1-i, so the widest shift happens first.
  always_comb begin
    lvl_src[0] = in_stg;
    for (int i = 1; i < SAW; i++) lvl_src[i] = stg_q[i-1];
  end

  always_comb begin
    for (int i = 0; i < SAW; i++) stg_d[i] = stg_q[i];
    zero_d = zero_q;
    if (en) begin
      for (int i = 0; i < SAW; i++) stg_d[i] = apply_level(lvl_src[i], SAW - 1 - i);
      zero_d = (stg_d[SAW-1].dat == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SAW; i++) stg_q[i] <= '0;
      zero_q <= 1'b0;
    end else begin
      stg_q  <= stg_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = stg_q[SAW-1].vld;
  assign sh        = stg_q[SAW-1].dat;
  assign zero      = zero_q;
  assign bad_op    = stg_q[SAW-1].op > OP_ROR;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe at WIDTH=32: directed vectors, random stream, reset flush.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] d;
  logic [4:0]  sa;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh;
  logic        zero;
  logic        bad_op;

  int n_tests = 0;
  int n_fail  = 0;

  shift_pipe #(.WIDTH(32), .SAW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .sa(sa), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sh(sh), .zero(zero), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: shifts by arithmetic, rotates/SRA as repeated single-bit moves.
  function automatic logic [31:0] model(input logic [31:0] x, input int amt, input logic [2:0] o);
    logic [31:0] r;
    r = x;
    case (o)
      3'd0: r = x << amt;
      3'd1: r = x >> amt;
      3'd2: for (int i = 0; i < amt; i++) r = {r[31], r[31:1]};
      3'd3: for (int i = 0; i < amt; i++) r = {r[30:0], r[31]};
      3'd4: for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sa;
    logic [2:0]  op;
    logic [31:0] e_sh;
    logic        e_zero;
    logic        e_bad;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    d = v.d; sa = v.sa; op = v.op; in_valid = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'd5);
    chk($sformatf("v%0d_sh", idx), 64'(sh), 64'(v.e_sh));
    chk($sformatf("v%0d_zero", idx), 64'(zero), 64'(v.e_zero));
    chk($sformatf("v%0d_bad_op", idx), 64'(bad_op), 64'(v.e_bad));
  endtask

  typedef struct {
    logic [31:0] sh;
    logic        bad;
  } exp_t;

  initial begin
    exp_t        exp_q [$];
    exp_t        e;
    int          sent, got, stale;
    logic        pending, held_v;
    logic [33:0] held;

    vecs[0]  = '{32'h8000_00F0, 5'd4,  3'd2, 32'hF800_000F, 1'b0, 1'b0};
    vecs[1]  = '{32'h1234_5678, 5'd8,  3'd3, 32'h3456_7812, 1'b0, 1'b0};
    vecs[2]  = '{32'h1234_5678, 5'd8,  3'd4, 32'h7812_3456, 1'b0, 1'b0};
    vecs[3]  = '{32'h1234_5678, 5'd8,  3'd1, 32'h0012_3456, 1'b0, 1'b0};
    vecs[4]  = '{32'h1234_5678, 5'd8,  3'd0, 32'h3456_7800, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0001, 5'd1,  3'd1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{32'hDEAD_BEEF, 5'd7,  3'd6, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[8]  = '{32'hA5A5_0F0F, 5'd0,  3'd3, 32'hA5A5_0F0F, 1'b0, 1'b0};
    vecs[9]  = '{32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0000, 5'd3,  3'd5, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{32'h8000_0001, 5'd1,  3'd4, 32'hC000_0000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; d = '0; sa = '0; op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sh", 64'(sh), 64'd0);
    chk("rst_zero_bad", 64'({zero, bad_op}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Random stream with pseudo-random backpressure
    sent = 0; got = 0; pending = 1'b0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      @(negedge clk);
      if (held_v) chk("stall_stable", 64'({bad_op, zero, sh}), 64'(held));
      out_ready = ($urandom_range(0, 2) != 0);
      if (!pending) begin
        in_valid = 1'b0;
        if (sent < 20) begin
          d = $urandom; sa = 5'($urandom_range(0, 31)); op = 3'($urandom_range(0, 7));
          in_valid = 1'b1;
          pending = 1'b1;
        end
      end
      #1;
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      held_v = out_valid && !out_ready;
      held   = {bad_op, zero, sh};
      if (in_valid && in_ready) begin
        e.sh  = model(d, int'(sa), op);
        e.bad = (op > 3'd4);
        exp_q.push_back(e);
        sent++;
        pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_result", 64'(sh), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream_%0d", got), 64'({bad_op, zero, sh}),
              64'({e.bad, (e.sh == 32'd0), e.sh}));
        end
        got++;
      end
    end
    chk("stream_count", 64'(got), 64'd20);

    // Reset with three requests in flight
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      d = 32'h0F0F_0000 + 32'(i); sa = 5'(i + 1); op = 3'd3; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_outputs", 64'({bad_op, zero, sh}), 64'd0);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("flush_no_stale", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
